// File: rtl/hog_frame_source.sv
// hog_frame_source
//   Parametrised pixel-stream source for the hog pipeline input. Emits whole
//   IMAGE_WIDTH x IMAGE_HEIGHT frames in one of four patterns (LFSR, x-ramp,
//   y-ramp, constant). Supports multi-frame runs, inter-frame gaps, frame
//   markers, abort, a valid/ready handshake that tolerates backpressure, and
//   a completion pulse.
//
// Ports
//   clk, rst          clock (rising edge), asynchronous active-low reset
//   start             one-cycle run request, honoured only when idle
//   abort             ends the run at the next beat boundary
//   mode, const_value pattern select / constant value, latched on start
//   pixel_ready       downstream ready
//   pixel_valid/pixel output beat
//   sof/eol/eof       first pixel of frame / last of line / last of frame
//   busy              streaming or in an inter-frame gap
//   done              one-cycle pulse when a run ends
//   frame_count       frames fully accepted since reset (wraps)
module hog_frame_source #(
    parameter int          DATA_WIDTH   = 8,
    parameter int          IMAGE_WIDTH  = 128,
    parameter int          IMAGE_HEIGHT = 256,
    parameter int          NUM_FRAMES   = 1,
    parameter int          GAP_CYCLES   = 0,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic [1:0]            mode,
    input  logic [DATA_WIDTH-1:0] const_value,
    input  logic                  pixel_ready,
    output logic                  pixel_valid,
    output logic [DATA_WIDTH-1:0] pixel,
    output logic                  sof,
    output logic                  eol,
    output logic                  eof,
    output logic                  busy,
    output logic                  done,
    output logic [15:0]           frame_count
);

    localparam int XW = (IMAGE_WIDTH  > 1) ? $clog2(IMAGE_WIDTH)  : 1;
    localparam int YW = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1;
    localparam logic [XW-1:0] X_LAST    = XW'(IMAGE_WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST    = YW'(IMAGE_HEIGHT - 1);
    localparam logic [15:0]   LFSR_MASK = 16'hB400;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1,
        S_GAP    = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [XW-1:0]         x_q, x_d;
    logic [YW-1:0]         y_q, y_d;
    logic [15:0]           lfsr_q, lfsr_d;
    logic [1:0]            mode_q, mode_d;
    logic [DATA_WIDTH-1:0] const_q, const_d;
    logic [31:0]           run_cnt_q, run_cnt_d;
    logic [15:0]           frame_count_q, frame_count_d;
    logic [31:0]           gap_cnt_q, gap_cnt_d;
    logic                  abort_pend_q, abort_pend_d;

    logic                  xfer;
    logic                  last_x;
    logic                  last_y;
    logic                  last_pix;
    logic                  abort_req;
    logic [DATA_WIDTH-1:0] x_pat;
    logic [DATA_WIDTH-1:0] y_pat;
    logic [DATA_WIDTH-1:0] pat;

    // Ramp patterns are coordinates modulo 2^DATA_WIDTH: truncate or
    // zero-extend depending on which side is wider.
    if (XW >= DATA_WIDTH) begin : g_xpat_trunc
        assign x_pat = x_q[DATA_WIDTH-1:0];
    end else begin : g_xpat_ext
        assign x_pat = {{(DATA_WIDTH-XW){1'b0}}, x_q};
    end

    if (YW >= DATA_WIDTH) begin : g_ypat_trunc
        assign y_pat = y_q[DATA_WIDTH-1:0];
    end else begin : g_ypat_ext
        assign y_pat = {{(DATA_WIDTH-YW){1'b0}}, y_q};
    end

    always_comb begin
        pat = '0;
        case (mode_q)
            2'd0:    pat = lfsr_q[DATA_WIDTH-1:0];
            2'd1:    pat = x_pat;
            2'd2:    pat = y_pat;
            default: pat = const_q;
        endcase
    end

    // All beat outputs decode from registered state only, so they cannot
    // change while a beat is stalled (state only moves on a transfer).
    assign pixel_valid = (state_q == S_STREAM);
    assign xfer        = pixel_valid && pixel_ready;
    assign last_x      = (x_q == X_LAST);
    assign last_y      = (y_q == Y_LAST);
    assign last_pix    = last_x && last_y;
    assign abort_req   = abort || abort_pend_q;

    assign pixel       = pixel_valid ? pat : '0;
    assign sof         = pixel_valid && (x_q == '0) && (y_q == '0);
    assign eol         = pixel_valid && last_x;
    assign eof         = pixel_valid && last_pix;
    assign busy        = (state_q == S_STREAM) || (state_q == S_GAP);
    assign done        = (state_q == S_DONE);
    assign frame_count = frame_count_q;

    always_comb begin
        state_d       = state_q;
        x_d           = x_q;
        y_d           = y_q;
        lfsr_d        = lfsr_q;
        mode_d        = mode_q;
        const_d       = const_q;
        run_cnt_d     = run_cnt_q;
        frame_count_d = frame_count_q;
        gap_cnt_d     = gap_cnt_q;
        abort_pend_d  = abort_pend_q;

        case (state_q)
            S_IDLE: begin
                // start beats a simultaneous abort simply because abort is
                // not looked at here
                if (start) begin
                    state_d      = S_STREAM;
                    x_d          = '0;
                    y_d          = '0;
                    lfsr_d       = LFSR_SEED;
                    mode_d       = mode;
                    const_d      = const_value;
                    run_cnt_d    = '0;
                    abort_pend_d = 1'b0;
                end
            end

            S_STREAM: begin
                if (xfer) begin
                    // Galois, right shift; advanced per accepted beat only
                    lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_MASK : 16'h0000);

                    if (last_x) begin
                        x_d = '0;
                        y_d = last_y ? '0 : y_q + 1'b1;
                    end else begin
                        x_d = x_q + 1'b1;
                    end

                    if (last_pix) begin
                        frame_count_d = frame_count_q + 16'd1;
                        run_cnt_d     = run_cnt_q + 32'd1;
                    end

                    abort_pend_d = 1'b0;
                    if (abort_req) begin
                        state_d = S_DONE;
                    end else if (last_pix) begin
                        if ((NUM_FRAMES != 0) && (run_cnt_q + 32'd1 == 32'(NUM_FRAMES))) begin
                            state_d = S_DONE;
                        end else if (GAP_CYCLES > 0) begin
                            state_d   = S_GAP;
                            gap_cnt_d = 32'(GAP_CYCLES - 1);
                        end
                    end
                end else if (abort) begin
                    // beat is stalled: remember the request until it drains
                    abort_pend_d = 1'b1;
                end
            end

            S_GAP: begin
                if (abort_req) begin
                    state_d      = S_DONE;
                    abort_pend_d = 1'b0;
                end else if (gap_cnt_q == '0) begin
                    state_d = S_STREAM;
                end else begin
                    gap_cnt_d = gap_cnt_q - 32'd1;
                end
            end

            default: begin
                state_d      = S_IDLE;
                abort_pend_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= S_IDLE;
            x_q           <= '0;
            y_q           <= '0;
            lfsr_q        <= LFSR_SEED;
            mode_q        <= '0;
            const_q       <= '0;
            run_cnt_q     <= '0;
            frame_count_q <= '0;
            gap_cnt_q     <= '0;
            abort_pend_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            x_q           <= x_d;
            y_q           <= y_d;
            lfsr_q        <= lfsr_d;
            mode_q        <= mode_d;
            const_q       <= const_d;
            run_cnt_q     <= run_cnt_d;
            frame_count_q <= frame_count_d;
            gap_cnt_q     <= gap_cnt_d;
            abort_pend_q  <= abort_pend_d;
        end
    end

endmodule

// File: tb/tb_hog_frame_source.sv
// Bench for hog_frame_source. Three 4x2 instances share clk/rst:
//   inst 0: one frame per run, no gap
//   inst 1: three frames per run, 2-cycle gap
//   inst 2: continuous, no gap
// A per-instance monitor checks every accepted beat against a frame model
// and checks that stalled beats hold; the directed sequence checks timing,
// status outputs and literal pixel values.
module tb_hog_frame_source;

    localparam int W  = 4;
    localparam int H  = 2;
    localparam int FR = W * H;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       start_s [3];
    logic       abort_s [3];
    logic       ready_s [3];
    logic [1:0] mode_s  [3];
    logic [7:0] cval_s  [3];
    logic       valid_s [3];
    logic [7:0] pix_s   [3];
    logic       sof_s   [3];
    logic       eol_s   [3];
    logic       eof_s   [3];
    logic       busy_s  [3];
    logic       done_s  [3];
    logic [15:0] fcnt_s [3];

    int checks = 0;
    int errors = 0;

    logic [15:0] lfsr_seq [256];
    logic [10:0] cap_mem  [3][64];
    int          cap_n    [3] = '{0, 0, 0};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected {pixel, sof, eol, eof} for beat n of a run
    function automatic logic [10:0] model_beat(input int n, input logic [1:0] m, input logic [7:0] c);
        int k, x, y;
        logic [7:0] p;
        k = n % FR;
        x = k % W;
        y = k / W;
        case (m)
            2'd0:    p = lfsr_seq[n % 256][7:0];
            2'd1:    p = 8'(x);
            2'd2:    p = 8'(y);
            default: p = c;
        endcase
        return {p, (k == 0), (x == W - 1), (k == FR - 1)};
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_inst
        hog_frame_source #(
            .DATA_WIDTH  (8),
            .IMAGE_WIDTH (W),
            .IMAGE_HEIGHT(H),
            .NUM_FRAMES  ((g == 0) ? 1 : ((g == 1) ? 3 : 0)),
            .GAP_CYCLES  ((g == 1) ? 2 : 0),
            .LFSR_SEED   (16'hACE1)
        ) u_dut (
            .clk        (clk),
            .rst        (rst),
            .start      (start_s[g]),
            .abort      (abort_s[g]),
            .mode       (mode_s[g]),
            .const_value(cval_s[g]),
            .pixel_ready(ready_s[g]),
            .pixel_valid(valid_s[g]),
            .pixel      (pix_s[g]),
            .sof        (sof_s[g]),
            .eol        (eol_s[g]),
            .eof        (eof_s[g]),
            .busy       (busy_s[g]),
            .done       (done_s[g]),
            .frame_count(fcnt_s[g])
        );

        int          n  = 0;
        logic [1:0]  m  = 2'd0;
        logic [7:0]  c  = 8'd0;
        logic        pv = 1'b0;
        logic        pr = 1'b0;
        logic [10:0] pb = '0;

        always @(negedge clk) begin
            logic [10:0] cur;
            cur = {pix_s[g], sof_s[g], eol_s[g], eof_s[g]};
            if (!rst) begin
                n  = 0;
                pv = 1'b0;
                pr = 1'b0;
            end else begin
                if (pv && !pr) begin
                    chk($sformatf("i%0d_stall_valid", g), 32'(valid_s[g]), 32'd1);
                    chk($sformatf("i%0d_stall_hold", g), 32'(cur), 32'(pb));
                end
                if (start_s[g] && !busy_s[g] && !done_s[g]) begin
                    n = 0;
                    m = mode_s[g];
                    c = cval_s[g];
                end
                if (valid_s[g] && ready_s[g]) begin
                    chk($sformatf("i%0d_beat%0d", g, n), 32'(cur), 32'(model_beat(n, m, c)));
                    cap_mem[g][cap_n[g] % 64] = cur;
                    cap_n[g]++;
                    n++;
                end
                pv = valid_s[g];
                pr = ready_s[g];
                pb = cur;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int g, input logic [1:0] m, input logic [7:0] c);
        start_s[g] = 1'b1;
        mode_s[g]  = m;
        cval_s[g]  = c;
        tick();
        start_s[g] = 1'b0;
    endtask

    initial begin
        logic [15:0] s;
        int          base;
        int          seen;
        logic [29:0] vbits, dbits;
        logic [7:0]  ramp_px  [8] = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd0, 8'd1, 8'd2, 8'd3};
        logic [2:0]  ramp_fl  [8] = '{3'b100, 3'b000, 3'b000, 3'b010, 3'b000, 3'b000, 3'b000, 3'b011};
        logic [7:0]  lfsr_px  [8] = '{8'hE1, 8'h70, 8'h38, 8'h9C, 8'h4E, 8'h27, 8'h13, 8'h89};

        s = 16'hACE1;
        for (int i = 0; i < 256; i++) begin
            lfsr_seq[i] = s;
            s = s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
        end

        for (int g = 0; g < 3; g++) begin
            start_s[g] = 1'b0;
            abort_s[g] = 1'b0;
            ready_s[g] = 1'b0;
            mode_s[g]  = 2'd0;
            cval_s[g]  = 8'd0;
        end
        rst = 1'b1;
        #1 rst = 1'b0;
        tick();
        tick();
        for (int g = 0; g < 3; g++) begin
            chk($sformatf("i%0d_rst_valid", g), 32'(valid_s[g]), 32'd0);
            chk($sformatf("i%0d_rst_pixel", g), 32'(pix_s[g]), 32'd0);
            chk($sformatf("i%0d_rst_flags", g), 32'({sof_s[g], eol_s[g], eof_s[g]}), 32'd0);
            chk($sformatf("i%0d_rst_busy", g), 32'(busy_s[g]), 32'd0);
            chk($sformatf("i%0d_rst_done", g), 32'(done_s[g]), 32'd0);
            chk($sformatf("i%0d_rst_fcnt", g), 32'(fcnt_s[g]), 32'd0);
        end
        rst = 1'b1;
        tick();

        // x-ramp, single frame, ready always high
        ready_s[0] = 1'b1;
        base = cap_n[0];
        do_start(0, 2'd1, 8'd0);
        chk("t1_first_valid", 32'(valid_s[0]), 32'd1);
        chk("t1_first_sof", 32'(sof_s[0]), 32'd1);
        repeat (8) tick();
        chk("t1_done", 32'(done_s[0]), 32'd1);
        chk("t1_valid_low", 32'(valid_s[0]), 32'd0);
        chk("t1_fcnt", 32'(fcnt_s[0]), 32'd1);
        tick();
        chk("t1_done_pulse", 32'(done_s[0]), 32'd0);
        chk("t1_idle_busy", 32'(busy_s[0]), 32'd0);
        chk("t1_nbeats", 32'(cap_n[0] - base), 32'd8);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("t1_px%0d", i), 32'(cap_mem[0][(base + i) % 64][10:3]), 32'(ramp_px[i]));
            chk($sformatf("t1_fl%0d", i), 32'(cap_mem[0][(base + i) % 64][2:0]), 32'(ramp_fl[i]));
        end

        // LFSR, ready always high
        base = cap_n[0];
        do_start(0, 2'd0, 8'd0);
        repeat (8) tick();
        chk("t2a_done", 32'(done_s[0]), 32'd1);
        chk("t2a_fcnt", 32'(fcnt_s[0]), 32'd2);
        tick();
        for (int i = 0; i < 8; i++)
            chk($sformatf("t2a_px%0d", i), 32'(cap_mem[0][(base + i) % 64][10:3]), 32'(lfsr_px[i]));

        // LFSR, ready 1-of-3; mode input changes after start and must be ignored
        ready_s[0] = 1'b0;
        base = cap_n[0];
        do_start(0, 2'd0, 8'd0);
        mode_s[0] = 2'd1;
        seen = 0;
        for (int cyc = 0; cyc < 100; cyc++) begin
            ready_s[0] = ((cyc % 3) == 2);
            tick();
            if (done_s[0]) begin
                seen = 1;
                break;
            end
        end
        chk("t2b_done_seen", 32'(seen), 32'd1);
        chk("t2b_fcnt", 32'(fcnt_s[0]), 32'd3);
        ready_s[0] = 1'b1;
        tick();
        chk("t2b_nbeats", 32'(cap_n[0] - base), 32'd8);
        for (int i = 0; i < 8; i++)
            chk($sformatf("t2b_px%0d", i), 32'(cap_mem[0][(base + i) % 64][10:3]), 32'(lfsr_px[i]));

        // three frames, y-ramp, 2-cycle gaps
        ready_s[1] = 1'b1;
        base = cap_n[1];
        do_start(1, 2'd2, 8'd0);
        for (int i = 0; i < 30; i++) begin
            vbits[i] = valid_s[1];
            dbits[i] = done_s[1];
            tick();
        end
        chk("t3_valid_pattern", 32'(vbits), 32'(30'b001111111100111111110011111111));
        chk("t3_done_pattern", 32'(dbits), 32'h1000_0000);
        chk("t3_fcnt", 32'(fcnt_s[1]), 32'd3);
        chk("t3_busy_end", 32'(busy_s[1]), 32'd0);
        chk("t3_nbeats", 32'(cap_n[1] - base), 32'd24);
        for (int i = 0; i < 24; i++)
            chk($sformatf("t3_px%0d", i), 32'(cap_mem[1][(base + i) % 64][10:3]), 32'((i % 8) / 4));

        // continuous constant, abort while stalled on beat 5 of frame 2
        ready_s[2] = 1'b1;
        base = cap_n[2];
        do_start(2, 2'd3, 8'h5A);
        for (int i = 0; i < 13; i++) begin
            chk($sformatf("t4_nobubble%0d", i), 32'(valid_s[2]), 32'd1);
            tick();
        end
        ready_s[2] = 1'b0;
        abort_s[2] = 1'b1;
        tick();
        abort_s[2] = 1'b0;
        tick();
        tick();
        chk("t4_stalled_valid", 32'(valid_s[2]), 32'd1);
        chk("t4_stalled_px", 32'(pix_s[2]), 32'h5A);
        ready_s[2] = 1'b1;
        tick();
        chk("t4_done", 32'(done_s[2]), 32'd1);
        chk("t4_valid_drop", 32'(valid_s[2]), 32'd0);
        chk("t4_fcnt", 32'(fcnt_s[2]), 32'd1);
        tick();
        chk("t4_done_pulse", 32'(done_s[2]), 32'd0);
        chk("t4_busy", 32'(busy_s[2]), 32'd0);
        chk("t4_nbeats", 32'(cap_n[2] - base), 32'd14);
        chk("t4_eof_fl", 32'(cap_mem[2][(base + 7) % 64][2:0]), 32'b011);
        chk("t4_sof_fl", 32'(cap_mem[2][(base + 8) % 64][2:0]), 32'b100);

        // abort in idle has no effect
        abort_s[2] = 1'b1;
        tick();
        abort_s[2] = 1'b0;
        chk("t5_idle_abort_busy", 32'(busy_s[2]), 32'd0);
        chk("t5_idle_abort_done", 32'(done_s[2]), 32'd0);

        // start while busy is ignored
        do_start(2, 2'd3, 8'hA5);
        tick();
        do_start(2, 2'd1, 8'd0);
        chk("t5_still_busy", 32'(busy_s[2]), 32'd1);
        chk("t5_px_kept", 32'(pix_s[2]), 32'hA5);
        chk("t5_no_sof", 32'(sof_s[2]), 32'd0);
        abort_s[2] = 1'b1;
        tick();
        abort_s[2] = 1'b0;
        chk("t5_abort_done", 32'(done_s[2]), 32'd1);
        tick();

        // start and abort together in idle: run begins
        start_s[2] = 1'b1;
        abort_s[2] = 1'b1;
        mode_s[2]  = 2'd1;
        tick();
        start_s[2] = 1'b0;
        abort_s[2] = 1'b0;
        chk("t5_sa_busy", 32'(busy_s[2]), 32'd1);
        chk("t5_sa_sof", 32'(sof_s[2]), 32'd1);
        chk("t5_sa_px", 32'(pix_s[2]), 32'd0);
        abort_s[2] = 1'b1;
        tick();
        abort_s[2] = 1'b0;
        chk("t5_sa_done", 32'(done_s[2]), 32'd1);
        tick();

        // asynchronous reset mid-frame
        do_start(2, 2'd0, 8'd0);
        tick();
        tick();
        #2 rst = 1'b0;
        #1;
        chk("t6_rst_valid", 32'(valid_s[2]), 32'd0);
        chk("t6_rst_busy", 32'(busy_s[2]), 32'd0);
        chk("t6_rst_fcnt2", 32'(fcnt_s[2]), 32'd0);
        chk("t6_rst_fcnt0", 32'(fcnt_s[0]), 32'd0);
        tick();
        tick();
        rst = 1'b1;
        tick();
        do_start(2, 2'd0, 8'd0);
        chk("t6_restart_sof", 32'(sof_s[2]), 32'd1);
        chk("t6_restart_px", 32'(pix_s[2]), 32'hE1);
        abort_s[2] = 1'b1;
        tick();
        abort_s[2] = 1'b0;
        chk("t6_abort_done", 32'(done_s[2]), 32'd1);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hog_frame_source.md
Name: hog_frame_source

Overview:
- Parametrised pixel-stream source that feeds the hog pipeline's pixel_valid/pixel_ready input.
- Generates whole frames of IMAGE_WIDTH x IMAGE_HEIGHT pixels in selectable patterns: LFSR pseudo-random, horizontal ramp, vertical ramp, or constant.
- Adds what a free-running random driver lacks: multi-frame runs, inter-frame gaps, frame markers, backpressure-correct handshake and completion status.
- Used in simulation benches and as an on-chip self-test source in front of hog.

Parameters:
DATA_WIDTH, 8, pixel width in bits; legal range 1..16.
IMAGE_WIDTH, 128, pixels per line; minimum 2.
IMAGE_HEIGHT, 256, lines per frame; minimum 2.
NUM_FRAMES, 1, frames per run; 0 = continuous until abort.
GAP_CYCLES, 0, idle cycles with valid low between frames.
LFSR_SEED, 16'hACE1, LFSR load value; must be nonzero.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous reset, active-low (0 = reset).
start  in  1  one-cycle run request; honoured only in IDLE.
abort  in  1  ends the run at the next legal point.
mode  in  2  0 LFSR, 1 x-ramp, 2 y-ramp, 3 constant; sampled on start.
const_value  in  DATA_WIDTH  pixel value for mode 3; sampled on start.
pixel_ready  in  1  downstream ready.
pixel_valid  out  1  pixel is valid.
pixel  out  DATA_WIDTH  pixel data.
sof  out  1  first pixel of frame (x=0, y=0).
eol  out  1  last pixel of line (x=IMAGE_WIDTH-1).
eof  out  1  last pixel of frame.
busy  out  1  high in STREAM and GAP.
done  out  1  one-cycle pulse when a run ends.
frame_count  out  16  frames fully accepted since reset; wraps at 65535 -> 0.

Behaviour:
- Reset: state IDLE; x=y=0; lfsr=LFSR_SEED. All outputs are 0: pixel_valid, pixel, sof, eol, eof, busy, done, frame_count.
- States: IDLE, STREAM, GAP, DONE.
- A beat transfers on a cycle with pixel_valid && pixel_ready.
- While pixel_valid=1 and pixel_ready=0, pixel, sof, eol and eof hold stable.
- pixel_valid never drops without a transfer, except on reset.
- IDLE -> STREAM on start. pixel_valid=1 with the first pixel (sof=1) on the cycle after start. start outside IDLE is ignored.
- Start loads lfsr=LFSR_SEED and latches mode and const_value. It clears x, y and the per-run frame counter.
- Pattern for the current beat:
  - mode 0: lfsr[DATA_WIDTH-1:0].
  - mode 1: x mod 2^DATA_WIDTH.
  - mode 2: y mod 2^DATA_WIDTH.
  - mode 3: const_value.
- LFSR is 16-bit Galois, right shift, mask 16'hB400. It advances only on a transfer.
- On each transfer x increments. At x=IMAGE_WIDTH-1, x wraps to 0 and y increments. At the last pixel, y wraps to 0.
- On eof transfer:
  - frame_count+1 and run counter+1.
  - If NUM_FRAMES!=0 and the run counter reaches NUM_FRAMES, go to DONE.
  - Otherwise, if GAP_CYCLES>0, go to GAP.
  - Otherwise stay in STREAM: next pixel (sof=1) is valid the following cycle with no bubble.
  - LFSR is not reseeded between frames of a run.
- GAP: pixel_valid=0 for exactly GAP_CYCLES cycles, then STREAM.
- DONE: done=1 for one cycle, busy=0, then IDLE.
- Abort behaviour:
  - Sampled when no beat is pending (GAP, or STREAM on a transfer cycle); next state is DONE.
  - If abort is high while a beat is stalled, the request is held internally until that beat transfers.
  - A frame cut short by abort does not increment frame_count.
  - Abort in IDLE has no effect.
- start and abort together in IDLE: start wins.
- Reset asserted mid-frame: all state returns to reset values immediately (asynchronous). No partial-frame resumption.

Test Plan:
- IMAGE_WIDTH=4, IMAGE_HEIGHT=2, mode 1, ready=1, start -> 8 beats, pixels 0,1,2,3,0,1,2,3.
  - sof on beat 0, eol on beats 3 and 7, eof on beat 7.
  - done pulse one cycle after the eof transfer; frame_count=1.
- Same config, mode 0, LFSR_SEED=16'hACE1, DATA_WIDTH=8 -> pixels track a reference Galois model (mask B400) beat-for-beat.
  - Toggling ready with a 1-of-3 duty gives an identical sequence. Values and flags stay stable during stalls.
- NUM_FRAMES=3, GAP_CYCLES=2, mode 2 -> three frames with pixels 0,0,0,0,1,1,1,1.
  - Exactly 2 valid-low cycles between frames; frame_count=3; one done pulse.
- NUM_FRAMES=0, GAP_CYCLES=0, mode 3, const_value=8'h5A -> continuous 5A with no bubble across eof->sof.
  - Abort at beat 5 of frame 2 with ready=0 -> that beat transfers when ready returns, then valid drops.
  - done pulses; frame_count=1.
- start pulsed while busy, and start+abort in IDLE -> second start ignored; simultaneous case begins a run.
- Reset (rst=0) asserted mid-frame with valid high -> pixel_valid, busy and frame_count read 0 before the next clock edge.
  - A new start after release restarts at sof with pixel = seed-derived value.
